multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the 8-bit processor: instruction byte = opcode[7:5], rd[4], rs[3], imm/shamt[2:0].
- Owns the PC, latches the instruction fetched at that PC, and walks FETCH/DECODE/EXEC/MEM/WB.
- Drives register-bank write enable, ALU control, writeback mux select and the data-memory request/acknowledge handshake.
- Sits between instruction memory, register bank, ALU and data memory.

Parameters:
- RESET_PC, 8'd1, PC value loaded on reset (address 0 holds no instruction).
- MEM_TIMEOUT, 15, cycles to wait for dmem_ack in MEM before faulting (range 1..255).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- run  in  1  when high, fetch new instructions; sampled only in FETCH
- instr  in  8  instruction byte at current pc (combinational from instruction memory)
- dmem_ack  in  1  data-memory completion strobe
- pc  out  8  program counter
- opcode  out  3  latched IR[7:5]
- rd_sel  out  1  latched IR[4]
- rs_sel  out  1  latched IR[3]
- imm  out  3  latched IR[2:0]
- alu_op  out  2  00 add, 01 shift-left-logical, 10/11 reserved (never driven)
- alu_src_imm  out  1  ALU B operand = zero-extended imm
- reg_we  out  1  one-cycle register-bank write strobe
- wb_sel_mem  out  1  writeback data from memory (1) or ALU (0)
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  write qualifier, valid with dmem_req
- halted  out  1  sticky; FSM in HALT
- illegal  out  1  sticky; halt caused by opcode 001/010/011
- timeout  out  1  sticky; halt caused by missing dmem_ack
- state_dbg  out  3  encoded current state

Behaviour:
- Reset: state=FETCH, pc=RESET_PC, IR=8'h00, all strobes/flags 0, timeout counter 0. Reset overrides every other input in the same cycle, including mid-MEM; an outstanding dmem_req drops on the next edge.
- FETCH:
  - run=0: hold, pc unchanged.
  - run=1: IR<=instr, pc<=pc+1 (mod 256, so 255 wraps to 0), go to DECODE.
- DECODE: pure decode cycle.
  - 000 add, 100 addi, 101 sw, 110 lw, 111 sll: go to EXEC.
  - 001/010/011: go to HALT with illegal<=1.
- EXEC: ALU controls valid for the whole cycle.
  - add: alu_op=00, alu_src_imm=0.
  - addi/sw/lw: alu_op=00, alu_src_imm=1.
  - sll: alu_op=01, alu_src_imm=1.
  - add/addi/sll go to WB; sw/lw go to MEM.
- MEM:
  - dmem_req=1 every cycle in MEM; dmem_we=1 for sw, 0 for lw.
  - Ack is sampled each MEM cycle, including the first, so minimum MEM length = 1 cycle.
  - On ack: sw goes to FETCH, lw goes to WB.
  - The counter increments on each MEM cycle without ack. When it reaches MEM_TIMEOUT: go to HALT, timeout<=1, dmem_req deasserts.
  - dmem_ack outside MEM is ignored.
- WB:
  - reg_we=1 for exactly this cycle.
  - wb_sel_mem=1 for lw, else 0.
  - Go to FETCH.
- HALT: absorbing; only reset exits. All strobes 0, pc frozen.
- Strobes are Moore outputs of state plus IR and are glitch-free registered-state decodes. alu_* hold their EXEC values through MEM/WB; reg_we is 0 outside WB.
- Cycles per instruction with zero-wait ack: add/addi/sll 4, sw 4, lw 5. Each memory wait cycle adds 1.
- State encoding in state_dbg: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[15:0] and retired_cnt[15:0], both reset to 0.
  - cycle_cnt increments every non-HALT cycle.
  - retired_cnt increments on the final state of each instruction (WB exit, or MEM exit for sw).
  - Both counters saturate at 16'hFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package cpu8_pkg:
  - opcode localparams OP_ADD=3'b000, OP_ADDI=3'b100, OP_SW=3'b101, OP_LW=3'b110, OP_SLL=3'b111;
  - alu_op encodings ALU_ADD=2'b00, ALU_SLL=2'b01;
  - state enum/encodings.
- One sub-module: mem_handshake_timer, holding the MEM-state counter and timeout compare (inputs: active, ack; output: expired).

Test Plan:
- Reset then run=1 with instr=8'b00010000 (add), zero-wait -> pc 1->2; state 0,1,2,4,0; reg_we high only in cycle 4; alu_op=00, alu_src_imm=0.
- instr=8'b10000111 (addi) -> imm=3'b111, alu_src_imm=1, reg_we one pulse, wb_sel_mem=0, 4 cycles.
- instr=8'b11010100 (lw), dmem_ack after 3 MEM cycles -> dmem_req high 3 cycles, dmem_we=0, then WB with wb_sel_mem=1, 7 cycles total.
- instr=8'b10101100 (sw), ack never, MEM_TIMEOUT=15 -> dmem_req high 15 cycles with dmem_we=1, then halted=1, timeout=1, pc frozen.
- instr=8'b00100000 (opcode 001) -> HALT after DECODE, illegal=1; further run/dmem_ack ignored until reset, then pc=8'd1.
- pc=8'hFF fetch -> pc wraps to 8'h00; assert reset during MEM -> next cycle state=FETCH, dmem_req=0, pc=RESET_PC.

Source files
------------

// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit multi-cycle processor: opcodes, ALU controls,
// sequencer state encoding and the instruction byte layout.
package cpu8_pkg;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned IMM_W  = 3;
    localparam int unsigned ALU_W  = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PERF_W = 16;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b100;
    localparam logic [OP_W-1:0] OP_SW   = 3'b101;
    localparam logic [OP_W-1:0] OP_LW   = 3'b110;
    localparam logic [OP_W-1:0] OP_SLL  = 3'b111;

    localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_W-1:0] ALU_SLL = 2'b01;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic             rd_sel;
        logic             rs_sel;
        logic [IMM_W-1:0] imm;
    } instr_t;

    // Opcodes 001/010/011 are unassigned and halt the machine.
    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || op[2];
    endfunction

endpackage

// File: rtl/mem_handshake_timer.sv
// Counts MEM cycles without dmem_ack; expired flags the cycle that reaches MEM_TIMEOUT.
module mem_handshake_timer
    import cpu8_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ack,
    output logic expired
);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || !active || ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // This unacknowledged cycle is the MEM_TIMEOUT-th one.
    assign expired = active && !ack && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit processor.
// Optional `MULTICYCLE_PERF_CNT_EN adds saturating cycle/retired counters.
module multicycle_control_fsm
    import cpu8_pkg::*;
#(
    parameter logic [7:0]  RESET_PC    = 8'd1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [7:0]       instr,
    input  logic             dmem_ack,
    output logic [PC_W-1:0]  pc,
    output logic [OP_W-1:0]  opcode,
    output logic             rd_sel,
    output logic             rs_sel,
    output logic [IMM_W-1:0] imm,
    output logic [ALU_W-1:0] alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic             wb_sel_mem,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state_dbg
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] retired_cnt
`endif
);

    state_t state, state_next;
    instr_t ir;
    logic   mem_expired;

    mem_handshake_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (state == ST_MEM),
        .ack     (dmem_ack),
        .expired (mem_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // PC, instruction register and sticky fault flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (state == ST_FETCH && run) begin
                ir <= instr_t'(instr);
                pc <= pc + PC_W'(1);
            end
            if (state == ST_DECODE && !is_legal(ir.opcode)) begin
                illegal <= 1'b1;
            end
            if (mem_expired) begin
                timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:  if (run) state_next = ST_DECODE;
            ST_DECODE: state_next = is_legal(ir.opcode) ? ST_EXEC : ST_HALT;
            ST_EXEC:   state_next = (ir.opcode == OP_SW || ir.opcode == OP_LW) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack) begin
                    state_next = (ir.opcode == OP_SW) ? ST_FETCH : ST_WB;
                end else if (mem_expired) begin
                    state_next = ST_HALT;
                end
            end
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_FETCH;
        endcase
    end

    // Moore decodes of the state register and IR; ALU controls persist from EXEC to WB.
    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel_mem  = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        halted      = (state == ST_HALT);
        state_dbg   = state;
        if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
            alu_op      = (ir.opcode == OP_SLL) ? ALU_SLL : ALU_ADD;
            alu_src_imm = (ir.opcode != OP_ADD);
        end
        if (state == ST_MEM) begin
            dmem_req = 1'b1;
            dmem_we  = (ir.opcode == OP_SW);
        end
        if (state == ST_WB) begin
            reg_we     = 1'b1;
            wb_sel_mem = (ir.opcode == OP_LW);
        end
    end

    assign opcode = ir.opcode;
    assign rd_sel = ir.rd_sel;
    assign rs_sel = ir.rs_sel;
    assign imm    = ir.imm;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic retire;
    assign retire = (state == ST_WB) || (state == ST_MEM && dmem_ack && ir.opcode == OP_SW);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state != ST_HALT && cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + PERF_W'(1);
            end
            if (retire && retired_cnt != '1) begin
                retired_cnt <= retired_cnt + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, hand-written corner sequences,
// and random instruction streams checked against an instruction-level timing model.
module tb_multicycle_control_fsm;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset, run, dmem_ack;
    logic [7:0] instr;
    logic [7:0] pc;
    logic [2:0] opcode, imm, state_dbg;
    logic       rd_sel, rs_sel, alu_src_imm, reg_we, wb_sel_mem;
    logic       dmem_req, dmem_we, halted, illegal, timeout;
    logic [1:0] alu_op;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [15:0] cycle_cnt, retired_cnt;
`endif

    multicycle_control_fsm #(
        .RESET_PC    (8'd1),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instr       (instr),
        .dmem_ack    (dmem_ack),
        .pc          (pc),
        .opcode      (opcode),
        .rd_sel      (rd_sel),
        .rs_sel      (rs_sel),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_we      (reg_we),
        .wb_sel_mem  (wb_sel_mem),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .halted      (halted),
        .illegal     (illegal),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
`ifdef MULTICYCLE_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ins;
        int         mem_len;   // MEM cycle carrying the ack; 0 = never ack
        int         cyc;
        int         we;
        int         req;
        int         dwe;
        logic       wbsel;
        logic [1:0] aop;
        logic       asrc;
        logic       halt;
        logic       ill;
        logic       to;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] pc_m;
    bit         halted_m;
    vec_t       tbl [12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b0; dmem_ack = 1'b0; instr = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pc_m = 8'd1;
        halted_m = 1'b0;
    endtask

    // Instruction-level expectation: cycle count and strobe totals from the opcode rules.
    function automatic vec_t model(input logic [7:0] ins, input int mem_len);
        vec_t       v;
        logic [2:0] op;
        bit         acked;
        op    = ins[7:5];
        acked = (mem_len >= 1) && (mem_len <= TO);
        v.ins = ins; v.mem_len = mem_len;
        v.cyc = 0; v.we = 0; v.req = 0; v.dwe = 0; v.wbsel = 1'b0;
        v.aop = 2'b00; v.asrc = 1'b0; v.halt = 1'b0; v.ill = 1'b0; v.to = 1'b0;
        case (op)
            3'b000, 3'b100, 3'b111: begin
                v.cyc = 4; v.we = 1;
                v.aop = (op == 3'b111) ? 2'b01 : 2'b00;
                v.asrc = (op != 3'b000);
            end
            3'b101: begin
                v.asrc = 1'b1;
                if (acked) begin
                    v.cyc = 3 + mem_len; v.req = mem_len; v.dwe = mem_len;
                end else begin
                    v.cyc = 3 + TO; v.req = TO; v.dwe = TO; v.halt = 1'b1; v.to = 1'b1;
                end
            end
            3'b110: begin
                v.asrc = 1'b1;
                if (acked) begin
                    v.cyc = 4 + mem_len; v.req = mem_len; v.we = 1; v.wbsel = 1'b1;
                end else begin
                    v.cyc = 3 + TO; v.req = TO; v.halt = 1'b1; v.to = 1'b1;
                end
            end
            default: begin
                v.cyc = 2; v.halt = 1'b1; v.ill = 1'b1;
            end
        endcase
        return v;
    endfunction

    // Runs one instruction from FETCH until the FSM is back in FETCH or HALT.
    task automatic apply_vec(input vec_t v, input string tag);
        int         cyc, we_n, req_n, dwe_n, memc;
        logic       wbsel, asrc;
        logic [1:0] aop;
        bit         done;
        if (halted_m) do_reset();
        cyc = 0; we_n = 0; req_n = 0; dwe_n = 0; memc = 0;
        wbsel = 1'b0; asrc = 1'b0; aop = 2'b00; done = 1'b0;
        run = 1'b1; instr = v.ins; dmem_ack = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            run   = 1'b0;
            instr = 8'($urandom);
            if (state_dbg == 3'd2) begin
                aop = alu_op; asrc = alu_src_imm;
            end
            if (reg_we) begin
                we_n++; wbsel = wb_sel_mem;
            end
            if (dmem_req) req_n++;
            if (dmem_we) dwe_n++;
            if (state_dbg == 3'd3) begin
                memc++;
                dmem_ack = (v.mem_len != 0) && (memc == v.mem_len);
            end else begin
                dmem_ack = 1'($urandom);
            end
            if (state_dbg == 3'd0 || state_dbg == 3'd5) done = 1'b1;
        end
        dmem_ack = 1'b0;
        pc_m = pc_m + 8'd1;
        halted_m = v.halt;
        check({tag, " cycles"},   cyc,               v.cyc);
        check({tag, " reg_we"},   we_n,              v.we);
        check({tag, " dmem_req"}, req_n,             v.req);
        check({tag, " dmem_we"},  dwe_n,             v.dwe);
        check({tag, " wb_sel"},   int'(wbsel),       int'(v.wbsel));
        check({tag, " alu_op"},   int'(aop),         int'(v.aop));
        check({tag, " alu_imm"},  int'(asrc),        int'(v.asrc));
        check({tag, " halted"},   int'(halted),      int'(v.halt));
        check({tag, " illegal"},  int'(illegal),     int'(v.ill));
        check({tag, " timeout"},  int'(timeout),     int'(v.to));
        check({tag, " state"},    int'(state_dbg),   v.halt ? 5 : 0);
        check({tag, " pc"},       int'(pc),          int'(pc_m));
        check({tag, " opcode"},   int'(opcode),      int'(v.ins[7:5]));
        check({tag, " rd_rs"},    int'({rd_sel, rs_sel}), int'(v.ins[4:3]));
        check({tag, " imm"},      int'(imm),         int'(v.ins[2:0]));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] legal_ops [5];
        int         exp_st [4];
        int         exp_we [4];
        int         wait_n;

        reset = 1'b1; run = 1'b0; dmem_ack = 1'b0; instr = 8'h00;
        legal_ops = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};

        //            ins          len cyc we req dwe wbs aop    imm halt ill to
        tbl[0]  = '{8'b00010000,  0,  4, 1,  0,  0, 0, 2'b00, 0, 0, 0, 0};
        tbl[1]  = '{8'b10000111,  0,  4, 1,  0,  0, 0, 2'b00, 1, 0, 0, 0};
        tbl[2]  = '{8'b11101010,  0,  4, 1,  0,  0, 0, 2'b01, 1, 0, 0, 0};
        tbl[3]  = '{8'b11010100,  3,  7, 1,  3,  0, 1, 2'b00, 1, 0, 0, 0};
        tbl[4]  = '{8'b11001011,  1,  5, 1,  1,  0, 1, 2'b00, 1, 0, 0, 0};
        tbl[5]  = '{8'b10101100,  1,  4, 0,  1,  1, 0, 2'b00, 1, 0, 0, 0};
        tbl[6]  = '{8'b10110001, 15, 18, 0, 15, 15, 0, 2'b00, 1, 0, 0, 0};
        tbl[7]  = '{8'b10101100,  0, 18, 0, 15, 15, 0, 2'b00, 1, 1, 0, 1};
        tbl[8]  = '{8'b00100000,  0,  2, 0,  0,  0, 0, 2'b00, 0, 1, 1, 0};
        tbl[9]  = '{8'b01011111,  0,  2, 0,  0,  0, 0, 2'b00, 0, 1, 1, 0};
        tbl[10] = '{8'b01100000,  0,  2, 0,  0,  0, 0, 2'b00, 0, 1, 1, 0};
        tbl[11] = '{8'b11000000, 16, 18, 0, 15,  0, 0, 2'b00, 1, 1, 0, 1};

        do_reset();
        check("reset state",    int'(state_dbg), 0);
        check("reset pc",       int'(pc), 1);
        check("reset ir",       int'({opcode, rd_sel, rs_sel, imm}), 0);
        check("reset strobes",  int'({reg_we, dmem_req, dmem_we, wb_sel_mem, alu_op, alu_src_imm}), 0);
        check("reset flags",    int'({halted, illegal, timeout}), 0);

        // run=0 holds in FETCH with pc unchanged
        repeat (3) @(negedge clk);
        check("idle state", int'(state_dbg), 0);
        check("idle pc",    int'(pc), 1);

        // add: per-cycle state and reg_we trace
        exp_st = '{1, 2, 4, 0};
        exp_we = '{0, 0, 1, 0};
        run = 1'b1; instr = 8'b00010000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run = 1'b0;
            check($sformatf("add trace state[%0d]", i), int'(state_dbg), exp_st[i]);
            check($sformatf("add trace reg_we[%0d]", i), int'(reg_we), exp_we[i]);
            if (i == 1) check("add exec alu", int'({alu_op, alu_src_imm}), 0);
        end
        check("add trace pc", int'(pc), 2);
        pc_m = 8'd2;

        for (int i = 0; i < 12; i++) begin
            apply_vec(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // HALT ignores run and dmem_ack; only reset leaves it
        apply_vec(model(8'b00111010, 0), "halt_entry");
        run = 1'b1; dmem_ack = 1'b1; instr = 8'b00010000;
        wait_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (state_dbg != 3'd5 || reg_we || dmem_req) wait_n++;
        end
        check("halt absorbing", wait_n, 0);
        check("halt pc frozen", int'(pc), int'(pc_m));
        check("halt sticky", int'({halted, illegal}), 3);
        do_reset();
        check("post-halt pc",    int'(pc), 1);
        check("post-halt flags", int'({halted, illegal, timeout}), 0);
        check("post-halt state", int'(state_dbg), 0);

        // reset asserted mid-MEM drops the request on the next edge
        run = 1'b1; instr = 8'b10100001;
        @(negedge clk);
        run = 1'b0;
        wait_n = 0;
        while (state_dbg != 3'd3 && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        @(negedge clk);
        check("mid-mem req", int'(dmem_req), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid-mem reset state", int'(state_dbg), 0);
        check("mid-mem reset req",   int'(dmem_req), 0);
        check("mid-mem reset pc",    int'(pc), 1);
        reset = 1'b0;
        pc_m = 8'd1; halted_m = 1'b0;
        apply_vec(model(8'b10100001, TO), "post-reset sw");

        // long legal stream forces pc through 255 -> 0
        for (int i = 0; i < 260; i++) begin
            logic [7:0] ins;
            ins = {legal_ops[$urandom_range(0, 4)], 5'($urandom)};
            apply_vec(model(ins, $urandom_range(1, 3)), $sformatf("wrap[%0d]", i));
            if (pc_m == 8'h00) check("pc wrap", int'(pc), 0);
        end

        // mixed stream including illegal opcodes and timeout boundaries
        for (int i = 0; i < 80; i++) begin
            logic [7:0] ins;
            int         r, len;
            ins = 8'($urandom);
            r   = $urandom_range(0, 9);
            len = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : $urandom_range(1, 4);
            apply_vec(model(ins, len), $sformatf("rand[%0d]", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
